// File: rtl/corr_pkg.sv
// corr_pkg: shared state encoding, timing defaults and stream word order for the correlator scheduler
package corr_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INTEG,
    S_SETTLE,
    S_CAPTURE
  } state_t;
  localparam int CLEAR_CYCLES_DEF = 4;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int HDR_IDX = 0;
  function automatic int ck_idx(input int num_words);
    return num_words + 1;
  endfunction
endpackage

// File: rtl/corr_snapshot_streamer.sv
// corr_snapshot_streamer: holds one captured snapshot and streams header, payload and XOR checksum
module corr_snapshot_streamer
  import corr_pkg::*;
#(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS = 8
) (
  input  logic                            pllclk,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic [RESOLUTION-1:0]           hdr_i,
  input  logic [NUM_WORDS*RESOLUTION-1:0] pulses_i,
  input  logic                            out_ready_i,
  output logic [RESOLUTION-1:0]           out_data_o,
  output logic                            out_valid_o,
  output logic                            out_last_o
);
  localparam int IW = $clog2(NUM_WORDS + 3);
  localparam logic [IW-1:0] LAST = IW'(ck_idx(NUM_WORDS));
  // header sits in the low word so every accepted word is simply shifted out
  logic [(NUM_WORDS+1)*RESOLUTION-1:0] sh_q;
  logic [RESOLUTION-1:0] csum_q;
  logic [IW-1:0] idx_q;
  logic valid_q;
  logic last;
  logic fire;
  assign last = idx_q == LAST;
  assign fire = valid_q && out_ready_i;
  assign out_valid_o = valid_q;
  assign out_last_o = valid_q && last;
  assign out_data_o = last ? csum_q : sh_q[RESOLUTION-1:0];
  always_ff @(posedge pllclk) begin
    if (!reset) begin
      sh_q <= '0;
      csum_q <= '0;
      idx_q <= IW'(HDR_IDX);
      valid_q <= 1'b0;
    end else if (start_i) begin
      sh_q <= {pulses_i, hdr_i};
      csum_q <= '0;
      idx_q <= IW'(HDR_IDX);
      valid_q <= 1'b1;
    end else if (fire) begin
      sh_q <= sh_q >> RESOLUTION;
      csum_q <= csum_q ^ sh_q[RESOLUTION-1:0];
      idx_q <= idx_q + IW'(1);
      valid_q <= !last;
    end
  end
endmodule

// File: rtl/corr_integration_sched.sv
// corr_integration_sched: sequences clear/integrate/settle/capture windows and streams each snapshot
module corr_integration_sched
  import corr_pkg::*;
#(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS = 8,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                            pllclk,
  input  logic                            reset,
  input  logic                            enable_i,
  input  logic                            continuous_i,
  input  logic [31:0]                     integration_cycles_i,
  input  logic [NUM_WORDS*RESOLUTION-1:0] pulses_i,
  output logic                            corr_clear_o,
  output logic                            busy_o,
  output logic [RESOLUTION-1:0]           out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o,
  output logic [RESOLUTION-1:0]           frame_count_o,
  output logic [7:0]                      overrun_count_o
);
  state_t state_q;
  logic [31:0] cnt_q;
  logic [31:0] n_q;
  logic clear_q;
  logic [RESOLUTION-1:0] frame_q;
  logic [7:0] ovr_q;
  logic str_busy;
  logic start;
  assign start = state_q == S_CAPTURE && !str_busy;
  assign corr_clear_o = clear_q;
  assign busy_o = state_q != S_IDLE;
  assign frame_count_o = frame_q;
  assign overrun_count_o = ovr_q;
  assign out_valid_o = str_busy;
  always_ff @(posedge pllclk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      n_q <= '0;
      clear_q <= 1'b1;
      frame_q <= '0;
      ovr_q <= '0;
    end else if (!enable_i && (state_q == S_CLEAR || state_q == S_INTEG || state_q == S_SETTLE)) begin
      state_q <= S_IDLE;
      clear_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (enable_i) begin
          state_q <= S_CLEAR;
          cnt_q <= 32'(CLEAR_CYCLES);
          n_q <= integration_cycles_i;
        end
        S_CLEAR: if (cnt_q == 32'd1) begin
          state_q <= S_INTEG;
          clear_q <= 1'b0;
          cnt_q <= n_q == 32'd0 ? 32'd1 : n_q;
        end else cnt_q <= cnt_q - 32'd1;
        S_INTEG: if (cnt_q == 32'd1) begin
          state_q <= S_SETTLE;
          cnt_q <= 32'(SETTLE_CYCLES);
        end else cnt_q <= cnt_q - 32'd1;
        S_SETTLE: if (cnt_q == 32'd1) begin
          state_q <= S_CAPTURE;
          clear_q <= 1'b1;
        end else cnt_q <= cnt_q - 32'd1;
        S_CAPTURE: begin
          // a capture while the previous stream is still draining is dropped but still numbered
          frame_q <= frame_q + RESOLUTION'(1);
          ovr_q <= str_busy && ovr_q != 8'hFF ? ovr_q + 8'd1 : ovr_q;
          state_q <= continuous_i && enable_i ? S_CLEAR : S_IDLE;
          cnt_q <= 32'(CLEAR_CYCLES);
          n_q <= continuous_i && enable_i ? integration_cycles_i : n_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  corr_snapshot_streamer #(
    .RESOLUTION(RESOLUTION),
    .NUM_WORDS(NUM_WORDS)
  ) u_streamer (
    .pllclk(pllclk),
    .reset(reset),
    .start_i(start),
    .hdr_i(frame_q),
    .pulses_i(pulses_i),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .out_valid_o(str_busy),
    .out_last_o(out_last_o)
  );
endmodule

// File: tb/tb_corr_integration_sched.sv
// tb_corr_integration_sched: directed scoreboard bench for the integration scheduler
module tb_corr_integration_sched;
  localparam int RES = 24;
  localparam int NW = 8;
  logic pllclk = 1'b0;
  logic reset = 1'b0;
  logic enable_i = 1'b0;
  logic continuous_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic [31:0] integration_cycles_i = '0;
  logic [NW*RES-1:0] pulses_i = '0;
  logic corr_clear_o, busy_o, out_valid_o, out_last_o;
  logic [RES-1:0] out_data_o, frame_count_o;
  logic [7:0] overrun_count_o;
  corr_integration_sched #(.RESOLUTION(RES), .NUM_WORDS(NW)) dut (
    .pllclk(pllclk),
    .reset(reset),
    .enable_i(enable_i),
    .continuous_i(continuous_i),
    .integration_cycles_i(integration_cycles_i),
    .pulses_i(pulses_i),
    .corr_clear_o(corr_clear_o),
    .busy_o(busy_o),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_last_o(out_last_o),
    .frame_count_o(frame_count_o),
    .overrun_count_o(overrun_count_o)
  );
  always #5 pllclk = ~pllclk;
  typedef struct packed {
    logic [RES-1:0] d;
    logic l;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int low_run = 0;
  int last_low = 0;
  logic prev_stall = 1'b0;
  logic [RES-1:0] prev_d = '0;
  logic prev_l = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge pllclk) begin
    exp_t e;
    if (reset) begin
      if (prev_stall && out_valid_o) begin
        chk("stall_data", out_data_o, prev_d);
        chk("stall_last", out_last_o, prev_l);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", out_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data_o, e.d);
          chk("word_last", out_last_o, e.l);
        end
      end
    end
    prev_stall = reset && out_valid_o && !out_ready_i;
    prev_d = out_data_o;
    prev_l = out_last_o;
    if (!corr_clear_o) low_run++;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run = 0;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge pllclk);
    #1;
  endtask
  function automatic logic [NW*RES-1:0] mk_pulses(input logic [7:0] seed);
    logic [NW*RES-1:0] p;
    for (int k = 0; k < NW; k++) p[k*RES+:RES] = {seed, 8'(k + 1), seed ^ 8'(k * 17)};
    return p;
  endfunction
  task automatic push_frame(input logic [RES-1:0] hdr, input logic [NW*RES-1:0] p);
    logic [RES-1:0] w;
    logic [RES-1:0] cs;
    cs = '0;
    for (int k = 0; k < NW + 2; k++) begin
      if (k == 0) w = hdr;
      else if (k == NW + 1) w = cs;
      else w = p[(k-1)*RES+:RES];
      cs ^= w;
      exp_q.push_back(exp_t'{d: w, l: (k == NW + 1)});
    end
  endtask
  task automatic do_reset;
    reset = 1'b0;
    enable_i = 1'b0;
    continuous_i = 1'b0;
    tick(2);
    chk("rst_clear", corr_clear_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_frame", frame_count_o, 0);
    chk("rst_ovr", overrun_count_o, 0);
    reset = 1'b1;
  endtask
  task automatic wait_valid;
    int n = 0;
    while (!out_valid_o && n < 200) begin
      @(negedge pllclk);
      n++;
    end
    chk("valid_timeout", out_valid_o, 1);
  endtask
  task automatic wait_done;
    int n = 0;
    do begin
      @(negedge pllclk);
      n++;
    end while ((out_valid_o || busy_o || exp_q.size() != 0) && n < 400);
    chk("drain", {out_valid_o, busy_o, exp_q.size() == 0}, 3'b001);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    do_reset;
    pulses_i = mk_pulses(8'h11);
    integration_cycles_i = 10;
    out_ready_i = 1'b1;
    push_frame(0, pulses_i);
    enable_i = 1'b1;
    wait_valid;
    enable_i = 1'b0;
    wait_done;
    chk("t1_low_cycles", last_low, 12);
    chk("t1_frame", frame_count_o, 1);
    chk("t1_clear", corr_clear_o, 1);
    chk("t1_ovr", overrun_count_o, 0);
    do_reset;
    pulses_i = mk_pulses(8'h5A);
    integration_cycles_i = 0;
    push_frame(0, pulses_i);
    enable_i = 1'b1;
    wait_valid;
    enable_i = 1'b0;
    wait_done;
    chk("t2_low_cycles", last_low, 3);
    chk("t2_frame", frame_count_o, 1);
    do_reset;
    continuous_i = 1'b1;
    integration_cycles_i = 3;
    out_ready_i = 1'b0;
    pulses_i = mk_pulses(8'hC7);
    push_frame(0, pulses_i);
    enable_i = 1'b1;
    wait_valid;
    chk("t3_stall_hdr", out_data_o, 0);
    chk("t3_stall_last", out_last_o, 0);
    for (int i = 0; i < 100 && frame_count_o != 2; i++) @(negedge pllclk);
    enable_i = 1'b0;
    chk("t3_frame", frame_count_o, 2);
    chk("t3_ovr", overrun_count_o, 1);
    continuous_i = 1'b0;
    tick(5);
    out_ready_i = 1'b1;
    wait_done;
    chk("t3_ovr_end", overrun_count_o, 1);
    chk("t3_frame_end", frame_count_o, 2);
    do_reset;
    integration_cycles_i = 5;
    pulses_i = mk_pulses(8'h3C);
    push_frame(0, pulses_i);
    enable_i = 1'b1;
    wait_valid;
    enable_i = 1'b0;
    for (int i = 0; i < 60 && (out_valid_o || exp_q.size() != 0); i++) begin
      @(posedge pllclk);
      #1;
      out_ready_i = ~out_ready_i;
    end
    out_ready_i = 1'b1;
    wait_done;
    chk("t4_frame", frame_count_o, 1);
    do_reset;
    continuous_i = 1'b1;
    integration_cycles_i = 20;
    enable_i = 1'b1;
    tick(8);
    chk("t5_integrating", corr_clear_o, 0);
    enable_i = 1'b0;
    tick(1);
    chk("t5_abort_clear", corr_clear_o, 1);
    chk("t5_abort_busy", busy_o, 0);
    tick(40);
    chk("t5_frame", frame_count_o, 0);
    chk("t5_valid", out_valid_o, 0);
    continuous_i = 1'b0;
    do_reset;
    integration_cycles_i = 2;
    out_ready_i = 1'b0;
    pulses_i = mk_pulses(8'h99);
    enable_i = 1'b1;
    wait_valid;
    enable_i = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("t6_valid", out_valid_o, 0);
    chk("t6_last", out_last_o, 0);
    chk("t6_frame", frame_count_o, 0);
    chk("t6_ovr", overrun_count_o, 0);
    chk("t6_busy", busy_o, 0);
    reset = 1'b1;
    out_ready_i = 1'b1;
    integration_cycles_i = 1;
    pulses_i = mk_pulses(8'h42);
    push_frame(0, pulses_i);
    enable_i = 1'b1;
    wait_valid;
    enable_i = 1'b0;
    wait_done;
    chk("t6_frame_end", frame_count_o, 1);
    chk("t6_low_cycles", last_low, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
